// File: rtl/seq_shift_add_multiplier.sv
// seq_shift_add_multiplier: N x N shift-add multiplier, one multiplier bit per clock, signed/unsigned per operation
module seq_shift_add_multiplier #(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    output logic             busy,
    output logic             done,
    output logic [2*N-1:0]   product
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int CW = $clog2(N + 1);
    state_t state_q, state_d;
    logic [2*N-1:0] acc_q, acc_d, mag_a_q, mag_a_d, product_q, product_d;
    logic [N-1:0] mag_b_q, mag_b_d, abs_a, abs_b;
    logic [CW-1:0] count_q, count_d;
    logic neg_q, neg_d;
    assign abs_a = (signed_mode && a[N-1]) ? -a : a;
    assign abs_b = (signed_mode && b[N-1]) ? -b : b;
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mag_a_d   = mag_a_q;
        mag_b_d   = mag_b_q;
        count_d   = count_q;
        neg_d     = neg_q;
        product_d = product_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                mag_a_d = {{N{1'b0}}, abs_a};
                mag_b_d = abs_b;
                neg_d   = signed_mode & (a[N-1] ^ b[N-1]);
                acc_d   = '0;
                count_d = '0;
            end
            RUN: if (count_q == CW'(N)) begin
                state_d   = DONE;
                product_d = neg_q ? -acc_q : acc_q;
            end else begin
                acc_d   = acc_q + (mag_b_q[0] ? mag_a_q : '0);
                mag_a_d = mag_a_q << 1;
                mag_b_d = mag_b_q >> 1;
                count_d = count_q + CW'(1);
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mag_a_q   <= '0;
            mag_b_q   <= '0;
            count_q   <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mag_a_q   <= mag_a_d;
            mag_b_q   <= mag_b_d;
            count_q   <= count_d;
            neg_q     <= neg_d;
            product_q <= product_d;
        end
    end
    assign busy    = state_q != IDLE;
    assign done    = (state_q == DONE) & ~rst;
    assign product = product_q;
endmodule
